// File: rtl/nios_accel_pio_pkg.sv
// Shared definitions for the NIOS accelerometer PIO slaves: register map,
// bus width and parameter defaults.
package nios_accel_pio_pkg;

  // Avalon-MM data bus width shared by all accelerometer PIOs.
  localparam int unsigned DATA_W = 32;

  // Register map (word addresses).
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_OVERRUN = 2'd3;

  // Parameter defaults.
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned OVERRUN_W_DEF   = 16;

endpackage

// File: rtl/nios_accelerometer_sample_ready_if.sv
// Avalon-MM slave bus plus interrupt line for the sample-ready input PIO.
// master: NIOS side (drives address/strobes). slave: the PIO.
interface nios_accelerometer_sample_ready_if;
  import nios_accel_pio_pkg::*;

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

endinterface

// File: rtl/nios_accel_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, followed by a one-cycle
// rising-edge detector. Shared by the accelerometer input PIOs.
module nios_accel_sync_edge
  import nios_accel_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF  // legal range 2..4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw input in at bit 0; the top bit is the synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser chain and one-cycle delayed copy of the level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Level and rise are pure functions of flops, so rise lasts exactly one cycle.
  always_comb begin
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/nios_accelerometer_sample_ready.sv
// Avalon-MM input PIO returning the accelerometer sample-ready strobe.
// Synchronises in_port, latches rising edges into a sticky W1C flag and raises
// a maskable level interrupt. Zero-wait-state; readdata is combinational.
// Build option: define NIOS_ACCEL_SAMPLE_READY_OVERRUN_EN to include the
// saturating overrun counter at address 3; otherwise address 3 reads 0.
module nios_accelerometer_sample_ready
  import nios_accel_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,  // legal range 2..4
  parameter int unsigned CNT_W       = OVERRUN_W_DEF     // legal range 1..32
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    in_port,
  nios_accelerometer_sample_ready_if.slave        bus
);

  logic level;
  logic rise;

  nios_accel_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .async_i (in_port),
    .level_o (level),
    .rise_o  (rise)
  );

  logic wr_en;
  logic wr_mask;
  logic wr_edge;
  logic edge_clr;

  // Per-register write enables; reads carry no side effects.
  always_comb begin
    wr_en    = bus.chipselect & ~bus.write_n;
    wr_mask  = wr_en & (bus.address == ADDR_IRQMASK);
    wr_edge  = wr_en & (bus.address == ADDR_EDGECAP);
    edge_clr = wr_edge & bus.writedata[0];
  end

  logic irqmask_q, irqmask_d;
  logic edgecap_q, edgecap_d;

  // Mask load and sticky edge flag; a coincident edge beats the clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_mask) begin
      irqmask_d = bus.writedata[0];
    end
    if (rise) begin
      edgecap_d = 1'b1;
    end else if (edge_clr) begin
      edgecap_d = 1'b0;
    end
  end

  // Control/status register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= 1'b0;
      edgecap_q <= 1'b0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  logic [DATA_W-1:0] overrun_rd;

`ifdef NIOS_ACCEL_SAMPLE_READY_OVERRUN_EN
  logic [CNT_W-1:0] overrun_q, overrun_d;
  logic             wr_ovr;
  logic             ovr_inc;

  // Count an edge only if it lands on an already-set flag that is not being
  // cleared this cycle; any write to the register clears it, but a coincident
  // counted edge leaves it at 1.
  always_comb begin
    wr_ovr    = wr_en & (bus.address == ADDR_OVERRUN);
    ovr_inc   = rise & edgecap_q & ~edge_clr;
    overrun_d = overrun_q;
    if (wr_ovr) begin
      overrun_d = ovr_inc ? CNT_W'(1) : '0;
    end else if (ovr_inc && (overrun_q != {CNT_W{1'b1}})) begin
      overrun_d = overrun_q + CNT_W'(1);
    end
  end

  // Saturating overrun counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_rd = DATA_W'(overrun_q);
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
  assign overrun_rd   = '0;
`endif

  // Only bit 0 of writedata is meaningful to any register.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[DATA_W-1:1];

  logic [DATA_W-1:0] rdata;

  // Read mux keyed on address alone, independent of chipselect.
  always_comb begin
    rdata = '0;
    unique case (bus.address)
      ADDR_DATA:    rdata[0] = level;
      ADDR_IRQMASK: rdata[0] = irqmask_q;
      ADDR_EDGECAP: rdata[0] = edgecap_q;
      ADDR_OVERRUN: rdata    = overrun_rd;
      default:      rdata    = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = edgecap_q & irqmask_q;

endmodule

// File: tb/tb_nios_accelerometer_sample_ready.sv
// Directed bench for nios_accelerometer_sample_ready: a per-cycle vector table
// for the register/irq behaviour plus hand-written multi-cycle sequences for
// overrun counting, coincident events and reset mid-pulse.
module tb_nios_accelerometer_sample_ready;

`ifdef NIOS_ACCEL_SAMPLE_READY_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic in_port;

  int checks;
  int failures;

  nios_accelerometer_sample_ready_if bus ();
  nios_accelerometer_sample_ready_if bus2 ();

  nios_accelerometer_sample_ready dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  // Narrow-counter instance: never serviced, sees every edge of in_port.
  nios_accelerometer_sample_ready #(
    .SYNC_STAGES (2),
    .CNT_W       (2)
  ) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_port;
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] want_rd;
    logic        want_irq;
  } vec_t;

  localparam int NumVec = 22;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] want);
    bus.address = a;
    #1;
    check(name, bus.readdata, want);
  endtask

  task automatic rd2_check(input string name, input logic [1:0] a, input logic [31:0] want);
    bus2.address = a;
    #1;
    check(name, bus2.readdata, want);
  endtask

  task automatic irq_check(input string name, input logic want);
    check(name, {31'b0, bus.irq}, {31'b0, want});
  endtask

  // Single-cycle write; call at a negedge, returns just after the posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // One clean in_port pulse: 4 cycles high, 4 low; ends at a negedge.
  task automatic pulse();
    @(negedge clk);
    in_port = 1'b1;
    repeat (4) @(negedge clk);
    in_port = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            in    wr    waddr wdata          raddr rd             irq
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd1, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd2, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd3, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h1,         2'd1, 32'h1,         1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd0, 32'h1,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 32'h1,         1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 32'h1,         1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'h0,         2'd2, 32'h1,         1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h1,         2'd2, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 32'h0,         2'd1, 32'h0,         1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd0, 32'h1,         1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 32'h1,         1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 32'h1,         1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'd1, 32'h1,         2'd1, 32'h1,         1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0,         1'b0};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd3, 32'h0,         1'b0};
    vecs[20] = '{1'b0, 1'b1, 2'd0, 32'h1,         2'd0, 32'h0,         1'b0};
    vecs[21] = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFE, 2'd1, 32'h0,         1'b0};

    reset_n         = 1'b0;
    in_port         = 1'b0;
    bus.address     = 2'd0;
    bus.chipselect  = 1'b0;
    bus.write_n     = 1'b1;
    bus.writedata   = 32'h0;
    bus2.address    = 2'd3;
    bus2.chipselect = 1'b0;
    bus2.write_n    = 1'b1;
    bus2.writedata  = 32'h0;

    repeat (3) @(negedge clk);
    rd_check("in_reset_data", 2'd0, 32'h0);
    irq_check("in_reset_irq", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Per-cycle table: drive at negedge, sample just after the posedge.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      in_port = vecs[i].in_port;
      if (vecs[i].wr) begin
        bus.address    = vecs[i].waddr;
        bus.writedata  = vecs[i].wdata;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      rd_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].want_rd);
      irq_check($sformatf("vec%0d_irq", i), vecs[i].want_irq);
    end

    // dut2 has seen two edges with its flag never cleared.
    @(negedge clk);
    rd2_check("narrow_ovr_after_table", 2'd3, OvrEn ? 32'd1 : 32'd0);

    // Unserviced edges: flag stays set, extra edges counted (or ignored).
    repeat (OvrEn ? 3 : 5) pulse();
    rd_check("multi_edge_flag", 2'd2, 32'h1);
    rd_check("multi_edge_ovr", 2'd3, OvrEn ? 32'd2 : 32'd0);
    irq_check("multi_edge_irq_masked", 1'b0);
    @(negedge clk);
    bus_write(2'd3, 32'h0);
    rd_check("ovr_write_clears", 2'd3, 32'h0);

    // Rise coincides with the EDGECAP clear: edge wins, no overrun count.
    @(negedge clk);
    in_port = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(2'd2, 32'h1);
    rd_check("edge_vs_clr_flag", 2'd2, 32'h1);
    rd_check("edge_vs_clr_ovr", 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    in_port = 1'b0;
    repeat (4) @(negedge clk);

    // Counted edge coincides with the OVERRUN clear: count restarts at 1.
    in_port = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(2'd3, 32'h0000_1234);
    rd_check("edge_vs_ovr_clr", 2'd3, OvrEn ? 32'd1 : 32'd0);
    rd_check("edge_vs_ovr_clr_flag", 2'd2, 32'h1);
    repeat (2) @(negedge clk);
    in_port = 1'b0;
    repeat (4) @(negedge clk);

    // dut2 has now seen 7 (or 9) unserviced edges: 2-bit counter pinned at 3.
    rd2_check("narrow_ovr_saturated", 2'd3, OvrEn ? 32'd3 : 32'd0);
    rd2_check("narrow_flag", 2'd2, 32'h1);

    // Unmasking a pending flag raises irq on the next cycle.
    @(negedge clk);
    bus_write(2'd1, 32'h1);
    irq_check("unmask_pending_irq", 1'b1);

    // Reset mid-pulse: everything clears at once, regardless of the clock.
    @(negedge clk);
    in_port = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    irq_check("midreset_irq", 1'b0);
    rd_check("midreset_data", 2'd0, 32'h0);
    rd_check("midreset_mask", 2'd1, 32'h0);
    rd_check("midreset_flag", 2'd2, 32'h0);
    rd_check("midreset_ovr", 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // in_port high at reset release is captured as one edge.
    repeat (2) @(negedge clk);
    rd_check("release_data_level", 2'd0, 32'h1);
    rd_check("release_flag_not_yet", 2'd2, 32'h0);
    @(negedge clk);
    rd_check("release_flag_set", 2'd2, 32'h1);
    irq_check("release_irq_mask_reset", 1'b0);
    in_port = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_accelerometer_sample_ready.md
# nios_accelerometer_sample_ready

Avalon-MM input port that returns the accelerometer front-end's sample-ready strobe to the NIOS: the receive-side counterpart of the sample-tick output port. It synchronises the asynchronous `in_port` strobe, captures rising edges into a sticky write-1-to-clear flag, and raises a maskable interrupt. An optional saturating counter records rising edges that arrive while the flag is still set, so firmware can detect dropped samples. Zero-wait-state slave on the same NIOS data bus as the other accelerometer PIOs.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in the `in_port` synchroniser; legal range 2..4.
- `CNT_W`, 16: overrun counter width; legal range 1..32.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  1  sample-ready strobe from the accelerometer front-end; asynchronous to `clk`; minimum high or low time is SYNC_STAGES+1 clk cycles.
- `readdata`  out  32  read data; combinational, read latency 0.
- `irq`  out  1  active-high level interrupt.

## Operation
- Write enable for register A: `chipselect && !write_n && address == A`. Reads have no side effects.
- Address 0, DATA (RO): bit0 = synchronised `in_port` level. Bits 31:1 read 0. Writes are ignored.
- Address 1, IRQMASK (RW): bit0 stored from `writedata[0]`. Bits 31:1 read 0.
- Address 2, EDGECAP (R/W1C): bit0 is the sticky rising-edge flag.
  - Set on a detected rising edge.
  - Cleared by a write with `writedata[0]=1`; a write with `writedata[0]=0` has no effect.
- Address 3, OVERRUN (R, write-any-clears): CNT_W-bit count, zero-extended to 32 bits.
  - Increments when a rising edge is detected while EDGECAP=1 and EDGECAP is not being cleared in that cycle.
  - Saturates at all-ones; no wrap.
- Rising edge: `sync_q & ~prev_q`, where `prev_q` is `sync_q` delayed one cycle.
- `irq = EDGECAP & IRQMASK`.
- `readdata` muxes on `address` alone. It does not depend on `chipselect`.
- Reset values: `readdata` = DATA register, which is 0 after reset; `irq` 0; sync chain 0; `prev_q` 0; IRQMASK 0; EDGECAP 0; OVERRUN 0.
- If `in_port` is high at reset release, one rising edge is captured. This is intended: it flags a pending sample.
- Simultaneous events:
  - Edge and EDGECAP clear in the same cycle: edge wins; EDGECAP stays 1; OVERRUN does not increment.
  - Edge with EDGECAP=1 and OVERRUN clear in the same cycle: OVERRUN becomes 1.
  - IRQMASK write and edge in the same cycle: both take effect; `irq` reflects the new mask next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; pending edges are lost.

## Timing
- `in_port` rises and is stable before clk edge N.
  - DATA bit0 reads 1 after edge N+SYNC_STAGES-1.
  - EDGECAP sets at edge N+SYNC_STAGES.
  - `irq` (if masked in) rises in the same cycle as EDGECAP.
  - With the default SYNC_STAGES=2: DATA after edge N+1, EDGECAP after edge N+2.
- A register write takes effect at the clk edge where the enable is true. A read in the following cycle returns the new value.
- `irq` deasserts in the cycle after the clearing write's clock edge.
- `in_port` glitches shorter than one clk period may be missed. Such glitches are outside specification.

## Configuration
- `NIOS_ACCEL_SAMPLE_READY_OVERRUN_EN` defined: the OVERRUN counter and its logic are compiled in, as described above.
- Undefined: no counter flops are built; address 3 reads 0 and writes to it are ignored. All other behaviour is unchanged.

## Structure
- Shared package `nios_accel_pio_pkg`:
  - Address constants `ADDR_DATA`=0, `ADDR_IRQMASK`=1, `ADDR_EDGECAP`=2, `ADDR_OVERRUN`=3.
  - Defaults `SYNC_STAGES_DEF`=2 and `OVERRUN_W_DEF`=16.
- Sub-module `nios_accel_sync_edge`:
  - Parameterised synchroniser plus `prev_q`.
  - Outputs `level` and a one-cycle `rise` pulse.
  - Reused by other accelerometer input PIOs.
- The top level holds the register file, the counter and the read mux.

## Test plan
- Reset with `in_port`=0, then read all four addresses → all 0; `irq`=0.
- Write IRQMASK=1; pulse `in_port` high for 4 cycles before edge N → EDGECAP=1 and `irq`=1 after edge N+2. Write EDGECAP with 0x1 → `irq`=0 next cycle. Write 0x0 instead → no change.
- IRQMASK=0 with an edge → EDGECAP=1, `irq`=0. Then write IRQMASK=1 → `irq`=1 the next cycle.
- Three edges without clearing → EDGECAP=1, OVERRUN=2. Write any value to address 3 → OVERRUN=0. With CNT_W=2 and 6 unserviced edges → OVERRUN saturates at 3.
- A rise pulse coincides with the EDGECAP clear write → EDGECAP stays 1, OVERRUN unchanged. With EDGECAP=1, an edge coincides with the OVERRUN clear → OVERRUN=1.
- Macro undefined → address 3 reads 0 after 5 unserviced edges. Assert `reset_n` mid-pulse → all registers 0 and `irq`=0 immediately.
